col_parity_ctrl: RTL

//  Sequencer for the column-parity datapath (slice counter, previous-line register, colParity).
//  On start it walks all state slices in order, one 25-bit line per slice, and writes one

---
 rtl/col_parity_ctrl.sv | 53 +++++
 1 files changed

// File: rtl/col_parity_ctrl.sv
// col_parity_ctrl: Moore sequencer that walks all slices once per run, driving the
// slice counter, the previous-line register load and the memory read/write strobes.
module col_parity_ctrl #(
    parameter int NUM_SLICES = 64,
    parameter int CNT_W      = 7,
    parameter int ADDR_W     = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  cnt_value,
    output logic              cnt_en,
    output logic              cnt_rst,
    output logic              inreg_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy,
    output logic              done
);
    typedef enum logic [2:0] {IDLE, PRELOAD, CAPTURE, READ, CALC, DONE} state_t;
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(NUM_SLICES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SLICES - 1);
    state_t state_q, state_d;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end
    // Termination compares the full counter, so a wider counter cannot wrap the address.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = start ? PRELOAD : IDLE;
            PRELOAD: state_d = CAPTURE;
            CAPTURE: state_d = READ;
            READ:    state_d = CALC;
            CALC:    state_d = (cnt_value == LAST_CNT) ? DONE : READ;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        cnt_rst  = (state_q == IDLE) || (state_q == PRELOAD);
        cnt_en   = state_q == CALC;
        inreg_en = (state_q == CAPTURE) || (state_q == CALC);
        rd_en    = (state_q == PRELOAD) || (state_q == READ);
        rd_addr  = (state_q == PRELOAD) ? LAST_ADDR :
                   (state_q == READ)    ? cnt_value[ADDR_W-1:0] : '0;
        wr_en    = state_q == CALC;
        wr_addr  = (state_q == CALC) ? cnt_value[ADDR_W-1:0] : '0;
        busy     = state_q != IDLE;
        done     = state_q == DONE;
    end
endmodule
